// File: rtl/div32x32_seq_if.sv
// Request/result bundle for the sequential 32-bit divider.
// The requester drives start/a/b through the master modport; the divider
// returns busy/done and the held quotient, remainder and divide-by-zero flag.
interface div32x32_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div32x32_seq.sv
// Sequential unsigned 32/32 restoring divider.
// One quotient bit is retired per clock over 32 ITER cycles, followed by a
// single DONE cycle that pulses done and can accept the next request.
// A zero divisor skips iteration and reports all-ones / dividend with the
// divide-by-zero flag. All visible outputs come straight from flops.
module div32x32_seq (
  input  logic           clk,
  input  logic           reset,
  div32x32_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rmd_q, rmd_d;
  logic        dbz_q, dbz_d;

  // Working datapath. The partial remainder is architecturally 33 bits wide,
  // but after any restoring step it is strictly below the divisor, so its top
  // bit is always zero; only the low 32 bits are stored and the 33-bit
  // shifted/trial values are rebuilt inside div_step.
  logic [31:0] wq_q, wq_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;

  // {next remainder, new quotient bit} from the current step.
  logic [32:0] step;
  logic [31:0] wq_shift;

  // One restoring step: shift in the next dividend bit, try subtracting the
  // divisor at 33 bits, and keep the difference only if it did not borrow.
  function automatic logic [32:0] div_step(
    input logic [31:0] rem,
    input logic        msb,
    input logic [31:0] dvs
  );
    logic [32:0] shifted;
    logic [32:0] trial;
    shifted = {rem, msb};
    trial   = shifted - {1'b0, dvs};
    if (!trial[32]) begin
      div_step = {trial[31:0], 1'b1};
    end else begin
      div_step = {shifted[31:0], 1'b0};
    end
  endfunction

  assign step     = div_step(rem_q, wq_q[31], dvs_q);
  assign wq_shift = {wq_q[30:0], step[0]};

  // Next-state, datapath and output decode; everything holds by default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    wq_d    = wq_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;

    case (state_q)
      ITER: begin
        rem_d = step[32:1];
        wq_d  = wq_shift;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          quot_d  = wq_shift;
          rmd_d   = step[32:1];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end

      IDLE, DONE: begin
        // DONE behaves like IDLE for acceptance, giving back-to-back operation.
        state_d = IDLE;
        if (bus.start) begin
          if (bus.b != 32'd0) begin
            wq_d    = bus.a;
            dvs_d   = bus.b;
            rem_d   = 32'd0;
            cnt_d   = 5'd0;
            state_d = ITER;
          end else begin
            quot_d  = 32'hFFFF_FFFF;
            rmd_d   = bus.a;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == ITER);
    done_d = (state_d == DONE);
  end

  // Control and visible result registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= 32'd0;
      rmd_q   <= 32'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working datapath registers; always reloaded before use, so no reset.
  always_ff @(posedge clk) begin
    wq_q  <= wq_d;
    dvs_q <= dvs_d;
    rem_q <= rem_d;
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dbz_q;

endmodule
